baud_rate_gen: RTL and testbench
================================

BAUD_RATE_GEN -- requirements
Module: baud_rate_gen

Interface
REQ-001 Parameter DIV_W, default 16, divisor width in bits; SHALL be a multiple of 8 in the range 8..32.
REQ-002 Parameter OS, default 16, oversample factor; SHALL be a power of two, at least 4.
REQ-003 Parameter RESET_DIV, default 325, divisor value after reset (50 MHz, 9600 baud, x16 oversample).
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 gen_en  in  1  generator enable; low freezes both divider chains.
REQ-007 wr_en  in  1  divisor byte write strobe.
REQ-008 wr_sel  in  2  divisor byte index; 0 is the least significant byte.
REQ-009 wr_data  in  8  divisor byte value.
REQ-010 rx_sync  in  1  single-cycle pulse marking start-bit detection; restarts the RX phase.
REQ-011 tx_os_tick  out  1  TX oversample tick, one cycle wide.
REQ-012 tx_bit_tick  out  1  TX bit-rate tick, one cycle wide.
REQ-013 rx_os_tick  out  1  RX oversample tick, one cycle wide.
REQ-014 rx_sample_tick  out  1  RX mid-bit sample tick, one cycle wide.
REQ-015 div_q  out  DIV_W  active divisor, for readback.

Function
REQ-016 All tick outputs SHALL be registered; each SHALL be high for exactly one cycle.
REQ-017 Divisor write path:
- NB = DIV_W/8.
- A write with wr_sel < NB-1 SHALL update that byte of the shadow register only.
- A write with wr_sel == NB-1 SHALL commit {wr_data, shadow[lower bytes]} to the active divisor on the same edge.
- A write with wr_sel >= NB SHALL be ignored.
REQ-018 A committed divisor SHALL NOT disturb a running count; each chain SHALL pick up the new value at its next reload.
REQ-019 TX chain, down counter tcnt (DIV_W bits); on each edge with gen_en high:
- If tcnt==0: tcnt <= active divisor and tx_os_tick <= 1.
- Otherwise: tcnt <= tcnt-1 and tx_os_tick <= 0.
- Resulting period SHALL be D+1 clocks for divisor D.
REQ-020 TX oversample counter tos (log2(OS) bits):
- SHALL increment and wrap on each cycle in which the TX chain registers a tick.
- When tos==OS-1 on such a cycle, tx_bit_tick <= 1, so it coincides with every OS-th tx_os_tick.
REQ-021 RX chain, counter rcnt and oversample counter ros: identical to the TX chain, except rx_sample_tick <= 1 on a tick cycle where ros==OS/2-1.
REQ-022 rx_sync sampled high with gen_en high SHALL:
- load rcnt <= active divisor and clear ros;
- force both RX ticks low that cycle.
- The TX chain is unaffected.
REQ-023 After an rx_sync edge:
- first rx_os_tick SHALL register D+1 edges later;
- first rx_sample_tick SHALL register on the (OS/2)-th rx_os_tick, then every OS rx_os_ticks.
REQ-024 gen_en low SHALL:
- hold tcnt, tos, rcnt and ros;
- drive all ticks low and ignore rx_sync.
- On re-enable, counting SHALL resume from the held values.
- Divisor writes SHALL be accepted regardless of gen_en.
REQ-025 D==0 SHALL give a tx_os_tick and an rx_os_tick on every enabled cycle.
REQ-026 Simultaneous commit and reload on the same edge: the counter SHALL load the old active divisor; the new value applies from the following reload.
REQ-027 Simultaneous rx_sync and commit: rcnt SHALL load the old active divisor.
REQ-028 div_q SHALL equal the active divisor at all times.

Reset
REQ-029 While rst_n is sampled low:
- active divisor and shadow SHALL be RESET_DIV;
- tcnt and rcnt SHALL be RESET_DIV; tos and ros SHALL be 0;
- all ticks SHALL be 0.
REQ-030 Reset SHALL override wr_en, rx_sync and gen_en; asserting reset mid-period SHALL discard the partial count.
REQ-031 First tx_os_tick after reset release SHALL register RESET_DIV+1 edges after the last reset edge.

Verification
REQ-032 Reset, gen_en=1, defaults -> tx_os_tick every 326 clocks; tx_bit_tick first at clock 5216, then every 5216; div_q=325.
REQ-033 Write sel0=0x03, then sel1=0x00 -> div_q=3 after the sel1 edge; the current 326-clock period completes, then ticks every 4 clocks; a lone sel0 write leaves div_q unchanged.
REQ-034 D=3, rx_sync pulse at edge t -> rx_os_tick registered at t+4 and every 4 thereafter; rx_sample_tick at t+32, then t+96; tx_os_tick phase unchanged.
REQ-035 D=3, gen_en low for 10 clocks mid-period -> no ticks during the gap; the tick arrives exactly 10 clocks later than it would have; rx_sync during the gap has no effect.
REQ-036 D=0 -> ticks every clock; tx_bit_tick every 16 clocks. Write sel2 with DIV_W=16 -> ignored. Reset asserted mid-period -> state returns to REQ-029 values.

Source files
------------

// File: rtl/baud_rate_gen.sv
// Baud rate generator: programmable divisor with separate TX and RX divider
// chains, each producing an oversample tick and a bit-rate / mid-bit tick.
module baud_rate_gen #(
  parameter int DIV_W     = 16,
  parameter int OS        = 16,
  parameter int RESET_DIV = 325
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gen_en,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [7:0]       wr_data,
  input  logic             rx_sync,
  output logic             tx_os_tick,
  output logic             tx_bit_tick,
  output logic             rx_os_tick,
  output logic             rx_sample_tick,
  output logic [DIV_W-1:0] div_q
);

  localparam int               NB      = DIV_W / 8;
  localparam int               OS_W    = $clog2(OS);
  localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(RESET_DIV);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OS - 1);
  localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OS / 2 - 1);

  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] shadow_div;
  logic [DIV_W-1:0] commit_val;
  logic             commit;
  logic             shadow_wr;

  logic [DIV_W-1:0] tcnt;
  logic [OS_W-1:0]  tos;
  logic [DIV_W-1:0] rcnt;
  logic [OS_W-1:0]  ros;

  // The top byte lands directly in the active divisor together with the
  // lower bytes already staged in the shadow; the shadow's own top byte is unused.
  assign commit    = wr_en && (int'(wr_sel) == NB - 1);
  assign shadow_wr = wr_en && (int'(wr_sel) <  NB - 1);

  // Assemble the value committed by a top-byte write.
  always_comb begin
    commit_val = shadow_div;
    commit_val[(NB-1)*8 +: 8] = wr_data;
  end

  // Divisor shadow and active registers; writes are accepted whether or not the generator runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_div <= RST_VAL;
      shadow_div <= RST_VAL;
    end else begin
      for (int b = 0; b < NB - 1; b++) begin
        if (shadow_wr && (int'(wr_sel) == b)) begin
          shadow_div[b*8 +: 8] <= wr_data;
        end
      end
      if (commit) begin
        active_div <= commit_val;
      end
    end
  end

  // TX chain: reload on zero (old divisor wins against a same-edge commit) and emit ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt        <= RST_VAL;
      tos         <= '0;
      tx_os_tick  <= 1'b0;
      tx_bit_tick <= 1'b0;
    end else if (gen_en) begin
      if (tcnt == '0) begin
        tcnt        <= active_div;
        tos         <= tos + 1'b1;
        tx_os_tick  <= 1'b1;
        tx_bit_tick <= (tos == OS_LAST);
      end else begin
        tcnt        <= tcnt - 1'b1;
        tx_os_tick  <= 1'b0;
        tx_bit_tick <= 1'b0;
      end
    end else begin
      tx_os_tick  <= 1'b0;
      tx_bit_tick <= 1'b0;
    end
  end

  // RX chain: same as TX, but a start-bit sync restarts the phase and the mid-bit tick fires at OS/2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt           <= RST_VAL;
      ros            <= '0;
      rx_os_tick     <= 1'b0;
      rx_sample_tick <= 1'b0;
    end else if (gen_en) begin
      if (rx_sync) begin
        rcnt           <= active_div;
        ros            <= '0;
        rx_os_tick     <= 1'b0;
        rx_sample_tick <= 1'b0;
      end else if (rcnt == '0) begin
        rcnt           <= active_div;
        ros            <= ros + 1'b1;
        rx_os_tick     <= 1'b1;
        rx_sample_tick <= (ros == OS_MID);
      end else begin
        rcnt           <= rcnt - 1'b1;
        rx_os_tick     <= 1'b0;
        rx_sample_tick <= 1'b0;
      end
    end else begin
      rx_os_tick     <= 1'b0;
      rx_sample_tick <= 1'b0;
    end
  end

  assign div_q = active_div;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Self-checking bench for baud_rate_gen: expected tick edges are queued per
// scenario and popped as the simulation reaches each edge.
module tb_baud_rate_gen;

  logic        clk;
  logic        rst_n;
  logic        gen_en;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        rx_sync;
  logic        tx_os_tick;
  logic        tx_bit_tick;
  logic        rx_os_tick;
  logic        rx_sample_tick;
  logic [15:0] div_q;

  int n_cmp = 0;
  int n_bad = 0;
  int rel   = 0;

  int q_tx[$];
  int q_txb[$];
  int q_rx[$];
  int q_rs[$];

  baud_rate_gen #(.DIV_W(16), .OS(16), .RESET_DIV(325)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .gen_en         (gen_en),
    .wr_en          (wr_en),
    .wr_sel         (wr_sel),
    .wr_data        (wr_data),
    .rx_sync        (rx_sync),
    .tx_os_tick     (tx_os_tick),
    .tx_bit_tick    (tx_bit_tick),
    .rx_os_tick     (rx_os_tick),
    .rx_sample_tick (rx_sample_tick),
    .div_q          (div_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; rel counts edges since the last reset edge.
  task automatic step();
    @(posedge clk);
    #1;
    rel++;
  endtask

  // Pop the expected tick pattern {tx_os, tx_bit, rx_os, rx_sample} for edge r.
  function automatic logic [3:0] exp_bits(input int r);
    logic [3:0] e;
    e = 4'b0000;
    if (q_tx.size() > 0 && q_tx[0] == r)   begin e[3] = 1'b1; void'(q_tx.pop_front());  end
    if (q_txb.size() > 0 && q_txb[0] == r) begin e[2] = 1'b1; void'(q_txb.pop_front()); end
    if (q_rx.size() > 0 && q_rx[0] == r)   begin e[1] = 1'b1; void'(q_rx.pop_front());  end
    if (q_rs.size() > 0 && q_rs[0] == r)   begin e[0] = 1'b1; void'(q_rs.pop_front());  end
    return e;
  endfunction

  // Drive the two-byte divisor write {8'h00, lo} on edges 1 and 2 after reset.
  task automatic drive_div(input logic [7:0] lo);
    wr_en   = (rel < 2);
    wr_sel  = (rel == 0) ? 2'd0 : 2'd1;
    wr_data = (rel == 0) ? lo : 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; gen_en = 1'b1; wr_en = 1'b1; wr_sel = 2'd1; wr_data = 8'h5a; rx_sync = 1'b1;
    repeat (3) step();
    rst_n = 1'b1; wr_en = 1'b0; rx_sync = 1'b0;
    q_tx.delete(); q_txb.delete(); q_rx.delete(); q_rs.delete();
    rel = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gen_en = 1'b1; wr_en = 1'b1; wr_sel = 2'd1; wr_data = 8'h00; rx_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick} !== 4'b0000) begin
        n_bad++;
        $display("[TB] FAIL reset_ticks: got %b want 0000", {tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick});
      end
      n_cmp++;
      if (div_q !== 16'd325) begin
        n_bad++;
        $display("[TB] FAIL reset_div: got %0d want 325", div_q);
      end
    end
  endtask

  task automatic test_defaults();
    logic [3:0] e;
    do_reset();
    for (int k = 1; k <= 16; k++) begin q_tx.push_back(326 * k); q_rx.push_back(326 * k); end
    q_txb.push_back(5216);
    q_rs.push_back(2608);
    while (rel < 5220) begin
      step();
      e = exp_bits(rel);
      n_cmp++;
      if ({tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick} !== e) begin
        n_bad++;
        $display("[TB] FAIL defaults_ticks edge %0d: got %b want %b", rel, {tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick}, e);
      end
    end
    n_cmp++;
    if (div_q !== 16'd325) begin
      n_bad++;
      $display("[TB] FAIL defaults_div: got %0d want 325", div_q);
    end
  endtask

  task automatic test_div_write();
    logic [3:0] e;
    do_reset();
    for (int m = 0; m <= 18; m++) begin q_tx.push_back(326 + 4 * m); q_rx.push_back(326 + 4 * m); end
    q_txb.push_back(386);
    q_rs.push_back(354);
    while (rel < 400) begin
      wr_en   = (rel < 3);
      wr_sel  = 2'(rel);
      wr_data = (rel == 0) ? 8'h03 : (rel == 1) ? 8'h00 : 8'hff;
      step();
      e = exp_bits(rel);
      n_cmp++;
      if ({tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick} !== e) begin
        n_bad++;
        $display("[TB] FAIL divwrite_ticks edge %0d: got %b want %b", rel, {tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick}, e);
      end
      if (rel >= 1 && rel <= 3) begin
        n_cmp++;
        if (div_q !== ((rel == 1) ? 16'd325 : 16'd3)) begin
          n_bad++;
          $display("[TB] FAIL divwrite_div edge %0d: got %0d want %0d", rel, div_q, (rel == 1) ? 325 : 3);
        end
      end
    end
  endtask

  task automatic test_rx_sync();
    logic [3:0] e;
    do_reset();
    for (int m = 0; m <= 31; m++) q_tx.push_back(326 + 4 * m);
    q_txb.push_back(386); q_txb.push_back(450);
    for (int m = 0; m < 4; m++) q_rx.push_back(326 + 4 * m);
    for (int m = 0; m <= 26; m++) q_rx.push_back(346 + 4 * m);
    q_rs.push_back(374); q_rs.push_back(438);
    while (rel < 452) begin
      drive_div(8'h03);
      rx_sync = (rel + 1 == 342);
      step();
      e = exp_bits(rel);
      n_cmp++;
      if ({tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick} !== e) begin
        n_bad++;
        $display("[TB] FAIL rxsync_ticks edge %0d: got %b want %b", rel, {tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick}, e);
      end
    end
    rx_sync = 1'b0;
  endtask

  task automatic test_gen_en_gap();
    logic [3:0] e;
    do_reset();
    q_tx.push_back(326); q_tx.push_back(330);
    q_rx.push_back(326); q_rx.push_back(330);
    for (int m = 0; m <= 14; m++) begin q_tx.push_back(344 + 4 * m); q_rx.push_back(344 + 4 * m); end
    q_txb.push_back(396);
    q_rs.push_back(364);
    while (rel < 400) begin
      drive_div(8'h03);
      gen_en  = !((rel + 1 >= 332) && (rel + 1 <= 341));
      rx_sync = (rel + 1 == 336);
      step();
      e = exp_bits(rel);
      n_cmp++;
      if ({tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick} !== e) begin
        n_bad++;
        $display("[TB] FAIL gap_ticks edge %0d: got %b want %b", rel, {tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick}, e);
      end
    end
    gen_en = 1'b1; rx_sync = 1'b0;
  endtask

  task automatic test_div_zero();
    logic [3:0] e;
    do_reset();
    for (int r = 326; r <= 370; r++) begin q_tx.push_back(r); q_rx.push_back(r); end
    q_txb.push_back(341); q_txb.push_back(357);
    q_rs.push_back(333); q_rs.push_back(349); q_rs.push_back(365);
    while (rel < 370) begin
      drive_div(8'h00);
      step();
      e = exp_bits(rel);
      n_cmp++;
      if ({tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick} !== e) begin
        n_bad++;
        $display("[TB] FAIL divzero_ticks edge %0d: got %b want %b", rel, {tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick}, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] e;
    do_reset();
    while (rel < 341) begin
      drive_div(8'h03);
      step();
    end
    rst_n = 1'b0; gen_en = 1'b1; wr_en = 1'b1; wr_sel = 2'd1; wr_data = 8'h00; rx_sync = 1'b1;
    step();
    n_cmp++;
    if ({tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick, div_q} !== {4'b0000, 16'd325}) begin
      n_bad++;
      $display("[TB] FAIL midreset_state: got ticks %b div %0d want 0000 325", {tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick}, div_q);
    end
    rst_n = 1'b1; wr_en = 1'b0; rx_sync = 1'b0;
    q_tx.delete(); q_txb.delete(); q_rx.delete(); q_rs.delete();
    rel = 0;
    q_tx.push_back(326); q_rx.push_back(326);
    while (rel < 330) begin
      step();
      e = exp_bits(rel);
      n_cmp++;
      if ({tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick} !== e) begin
        n_bad++;
        $display("[TB] FAIL midreset_ticks edge %0d: got %b want %b", rel, {tx_os_tick, tx_bit_tick, rx_os_tick, rx_sample_tick}, e);
      end
    end
    n_cmp++;
    if (div_q !== 16'd325) begin
      n_bad++;
      $display("[TB] FAIL midreset_div: got %0d want 325", div_q);
    end
  endtask

  initial begin
    rst_n = 1'b0; gen_en = 1'b1; wr_en = 1'b0; wr_sel = 2'd0; wr_data = 8'h00; rx_sync = 1'b0;
    test_reset();
    test_defaults();
    test_div_write();
    test_rx_sync();
    test_gen_en_gap();
    test_div_zero();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
